// File: rtl/seven_seg_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_capture_pkg
// Description : Shared seven-segment definitions. Holds the hex segment
//               patterns (GFEDCBA, active low), the blank pattern, the
//               default stability threshold and the tracker state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package seven_seg_capture_pkg;

  localparam int STABLE_CYCLES_DEFAULT = 4;

  // Segment patterns, bit order GFEDCBA, a 0 lights the segment
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_HELD  = 2'd2
  } track_state_t;

  // Forward table: nibble to segment pattern. The decoder inverts this so
  // encoder and decoder always share one source of truth.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

  // True when exactly one active-low digit enable is asserted
  function automatic logic one_low(input logic [3:0] an);
    logic hit;
    case (an)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: hit = 1'b1;
      default:                            hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seven_seg_to_hex.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_to_hex
// Description : Combinational segment-pattern to hex-nibble decoder. Any
//               pattern outside the hex table yields nibble 0 and bad=1.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_to_hex
  import seven_seg_capture_pkg::*;
(
  input  logic [6:0] seg_l,
  output logic [3:0] nibble,
  output logic       bad
);

  // Search the shared forward table for the observed pattern
  always_comb begin
    nibble = 4'h0;
    bad    = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (seg_l == hex_to_seg(4'(i))) begin
        nibble = 4'(i);
        bad    = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/seven_seg_capture.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_capture
// Description : Reader for a multiplexed active-low seven-segment bus.
//               Registers the bus, filters scan transitions and ghosting
//               with a stability tracker, decodes each digit and commits a
//               4-digit frame with a one-cycle valid strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_capture
  import seven_seg_capture_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  sseg_l,
  input  logic [3:0]  an_l,
  output logic [15:0] value,
  output logic [3:0]  digit_bad,
  output logic        valid
);

  localparam int              CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_THR = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [6:0]       s_seg;
  logic [3:0]       s_an;
  logic [6:0]       ref_seg;
  logic [3:0]       ref_an;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  track_state_t     state;
  track_state_t     state_nxt;
  logic             ref_load;
  logic             accept;
  logic             candidate;
  logic             same;
  logic             commit;
  logic [3:0]       dec_nibble;
  logic             dec_bad;
  logic [15:0]      shadow_val;
  logic [3:0]       shadow_bad;
  logic [3:0]       mask;

  assign candidate = one_low(s_an);
  assign same      = (s_an == ref_an) && (s_seg == ref_seg);
  assign commit    = (mask == 4'b1111);

  // The accepted digit is the reference, so decode the reference pattern
  seven_seg_to_hex u_dec (
    .seg_l  (ref_seg),
    .nibble (dec_nibble),
    .bad    (dec_bad)
  );

  // Input register: all downstream logic sees only these copies
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_seg <= SEG_BLANK;
      s_an  <= 4'b1111;
    end else begin
      s_seg <= sseg_l;
      s_an  <= an_l;
    end
  end

  // Tracker state, stability counter and reference sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      ref_seg <= SEG_BLANK;
      ref_an  <= 4'b1111;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (ref_load) begin
        ref_seg <= s_seg;
        ref_an  <= s_an;
      end
    end
  end

  // Tracker next state: a digit is accepted only after the reference has
  // already been seen STABLE_CYCLES times and is still present
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ref_load  = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (candidate) begin
          ref_load  = 1'b1;
          cnt_nxt   = CNT_ONE;
          state_nxt = ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (same) begin
          if (cnt >= CNT_THR) begin
            accept    = 1'b1;
            state_nxt = ST_HELD;
          end else if (cnt != CNT_MAX) begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end else if (candidate) begin
          ref_load = 1'b1;
          cnt_nxt  = CNT_ONE;
        end else begin
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end
      end
      ST_HELD: begin
        if (!same) begin
          if (candidate) begin
            ref_load  = 1'b1;
            cnt_nxt   = CNT_ONE;
            state_nxt = ST_TRACK;
          end else begin
            cnt_nxt   = '0;
            state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Shadow frame and mask; a commit edge copies the old shadow contents,
  // so an accept landing on the same edge belongs to the next frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_val <= 16'h0000;
      shadow_bad <= 4'b0000;
      mask       <= 4'b0000;
    end else begin
      for (int d = 0; d < 4; d++) begin
        if (accept && !ref_an[d]) begin
          shadow_val[d*4 +: 4] <= dec_nibble;
          shadow_bad[d]        <= dec_bad;
        end
      end
      mask <= (commit ? 4'b0000 : mask) | (accept ? ~ref_an : 4'b0000);
    end
  end

  // Output frame registers and the one-cycle valid strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value     <= 16'h0000;
      digit_bad <= 4'b0000;
      valid     <= 1'b0;
    end else begin
      valid <= commit;
      if (commit) begin
        value     <= shadow_val;
        digit_bad <= shadow_bad;
      end
    end
  end

endmodule
`default_nettype wire
